alu_cmd_scheduler: RTL and testbench

Command front-end that sits directly upstream of the `tinyalu` DUT and drives its `A`/`B`/`op`/`start` pins. It buffers ALU commands from a valid/ready source in a small FIFO and issues them one at a time using the tinyalu start/done protocol. Each result goes out on a valid/ready response port, tagged with its opcode. A watchdog turns a missing `done` into an error response so the stream never hangs.

---
 rtl/alu_cmd_scheduler_if.sv | 33 +++
 rtl/alu_cmd_scheduler.sv | 162 ++++++++++++++++
 tb/tb_alu_cmd_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_scheduler_if.sv
// Command, tinyalu-pin and response bundle for alu_cmd_scheduler.
// master = command source / ALU / response sink side; slave = the scheduler.
interface alu_cmd_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic        busy;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_start,
    input  rsp_valid, rsp_result, rsp_op, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, alu_start,
    output rsp_valid, rsp_result, rsp_op, rsp_err, busy
  );
endinterface

// File: rtl/alu_cmd_scheduler.sv
// Queues ALU commands and drives tinyalu start/done one at a time; pop one edge after push, rsp one edge after done.
// cmd_ready drops only when the FIFO is full; rsp held until rsp_ready; watchdog turns a lost done into an error rsp.

module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module alu_cmd_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset_n,
  alu_cmd_scheduler_if.slave bus
);
  localparam int WDW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state;
  cmd_t           head;
  cmd_t           in_cmd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic [WDW-1:0] wdog;

  assign in_cmd = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
  assign pop    = (state == IDLE) && !fifo_empty;

  assign bus.cmd_ready = !fifo_full;
  assign bus.busy      = (state != IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (bus.cmd_valid),
    .push_dat (in_cmd),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wdog           <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= '0;
      bus.alu_start  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_op     <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head.op != 3'd0 && head.op <= 3'd4) begin
              bus.alu_a     <= head.a;
              bus.alu_b     <= head.b;
              bus.alu_op    <= head.op;
              bus.alu_start <= 1'b1;
              wdog          <= '0;
              state         <= ISSUE;
            end else if (head.op != 3'd0) begin
              // Illegal opcodes answer directly without touching the ALU.
              bus.rsp_valid  <= 1'b1;
              bus.rsp_err    <= 1'b1;
              bus.rsp_result <= '0;
              bus.rsp_op     <= head.op;
              state          <= RESP;
            end
          end
        end
        ISSUE: begin
          // done is checked first so it wins a tie with the watchdog.
          if (bus.alu_done) begin
            bus.alu_start  <= 1'b0;
            bus.rsp_result <= bus.alu_result;
            bus.rsp_err    <= 1'b0;
            bus.rsp_op     <= bus.alu_op;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            bus.alu_start  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b1;
            bus.rsp_op     <= bus.alu_op;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Directed bench for alu_cmd_scheduler with a behavioural tinyalu (1-cycle add/and/xor, 3-cycle mul).
module tb_alu_cmd_scheduler;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_cmd_scheduler_if bus();

  alu_cmd_scheduler #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic        has_rsp;
    logic [15:0] res;
    logic        err;
    int          starts;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  op;
    logic        err;
  } rsp_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   rise_cnt = 0;
  int   rise_cyc[$];
  rsp_t rsp_q[$];
  bit   start_q = 1'b0;
  bit   hang    = 1'b0;
  int   lat_ovr = 0;
  int   mcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [2:0] op);
    if (lat_ovr != 0) return lat_ovr;
    return (op == 3'd4) ? 3 : 1;
  endfunction

  function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural tinyalu: done is a one-cycle pulse lat edges after start is first sampled.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt           <= 0;
      bus.alu_done   <= 1'b0;
      bus.alu_result <= 16'h0;
    end else if (!bus.alu_start) begin
      mcnt         <= 0;
      bus.alu_done <= 1'b0;
    end else begin
      mcnt           <= mcnt + 1;
      bus.alu_done   <= !hang && (mcnt == model_lat(bus.alu_op) - 1);
      bus.alu_result <= alu_calc(bus.alu_a, bus.alu_b, bus.alu_op);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.alu_start && !start_q) begin
      rise_cnt++;
      rise_cyc.push_back(cyc);
    end
    start_q = bus.alu_start;
    if (reset_n && bus.rsp_valid && bus.rsp_ready)
      rsp_q.push_back('{res: bus.rsp_result, op: bus.rsp_op, err: bus.rsp_err});
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int waits);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    waits = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      waits++;
    end
    if (waits == 200) chk("push_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    if (k == 300) chk("idle_timeout", 32'(k), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs [10];
  rsp_t        r;
  int          w;
  int          r0;
  int          hi;
  logic [15:0] sums [6];

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 3'd1, 1'b1, 16'h0100, 1'b0, 1};
    vecs[1] = '{8'h3C, 8'hF5, 3'd2, 1'b1, 16'h0034, 1'b0, 1};
    vecs[2] = '{8'h55, 8'hFF, 3'd3, 1'b1, 16'h00AA, 1'b0, 1};
    vecs[3] = '{8'h0C, 8'h0A, 3'd4, 1'b1, 16'h0078, 1'b0, 1};
    vecs[4] = '{8'hFF, 8'h02, 3'd4, 1'b1, 16'h01FE, 1'b0, 1};
    vecs[5] = '{8'h80, 8'h80, 3'd1, 1'b1, 16'h0100, 1'b0, 1};
    vecs[6] = '{8'h12, 8'h34, 3'd0, 1'b0, 16'h0000, 1'b0, 0};
    vecs[7] = '{8'h12, 8'h34, 3'd5, 1'b1, 16'h0000, 1'b1, 0};
    vecs[8] = '{8'hAB, 8'hCD, 3'd7, 1'b1, 16'h0000, 1'b1, 0};
    vecs[9] = '{8'h01, 8'h02, 3'd1, 1'b1, 16'h0003, 1'b0, 1};

    // Reset, with a command offered while reset is held.
    reset_n       = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'h77;
    bus.cmd_b     = 8'h11;
    bus.cmd_op    = 3'd1;
    repeat (3) @(negedge clk);
    chk("rst_alu_start", 32'(bus.alu_start), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_capture_busy", 32'(bus.busy), 32'd0);
    chk("rst_no_capture_start", 32'(rise_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Single add with cycle-exact latency.
    rsp_q.delete();
    push(8'h12, 8'h34, 3'd1, w);
    @(negedge clk);
    chk("add_start_e0", 32'(bus.alu_start), 32'd0);
    chk("add_busy_e0", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("add_start_e1", 32'(bus.alu_start), 32'd1);
    chk("add_alu_a", 32'(bus.alu_a), 32'h12);
    chk("add_alu_b", 32'(bus.alu_b), 32'h34);
    chk("add_alu_op", 32'(bus.alu_op), 32'd1);
    @(negedge clk);
    chk("add_done_e2", 32'(bus.alu_done), 32'd1);
    chk("add_rsp_valid_e2", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("add_rsp_valid_e3", 32'(bus.rsp_valid), 32'd1);
    chk("add_start_e3", 32'(bus.alu_start), 32'd0);
    chk("add_rsp_result", 32'(bus.rsp_result), 32'h0046);
    chk("add_rsp_op", 32'(bus.rsp_op), 32'd1);
    chk("add_rsp_err", 32'(bus.rsp_err), 32'd0);
    wait_idle();
    chk("add_nrsp", 32'(rsp_q.size()), 32'd1);

    // Table of single commands, one at a time.
    for (int i = 0; i < 10; i++) begin
      rsp_q.delete();
      r0 = rise_cnt;
      push(vecs[i].a, vecs[i].b, vecs[i].op, w);
      wait_idle();
      chk($sformatf("vec%0d_starts", i), 32'(rise_cnt - r0), 32'(vecs[i].starts));
      chk($sformatf("vec%0d_nrsp", i), 32'(rsp_q.size()), 32'(vecs[i].has_rsp));
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        chk($sformatf("vec%0d_res", i), 32'(r.res), 32'(vecs[i].res));
        chk($sformatf("vec%0d_op", i), 32'(r.op), 32'(vecs[i].op));
        chk($sformatf("vec%0d_err", i), 32'(r.err), 32'(vecs[i].err));
      end
    end

    // Back-to-back mixed ops, including spacing between start pulses.
    rsp_q.delete();
    rise_cyc.delete();
    push(8'hFF, 8'hFF, 3'd4, w);
    chk("mix_wait0", 32'(w), 32'd0);
    push(8'hF0, 8'h3C, 3'd3, w);
    chk("mix_wait1", 32'(w), 32'd0);
    push(8'hAA, 8'h0F, 3'd2, w);
    chk("mix_wait2", 32'(w), 32'd0);
    wait_idle();
    chk("mix_nrsp", 32'(rsp_q.size()), 32'd3);
    chk("mix_nrise", 32'(rise_cyc.size()), 32'd3);
    if (rsp_q.size() == 3) begin
      chk("mix_res0", 32'(rsp_q[0].res), 32'hFE01);
      chk("mix_res1", 32'(rsp_q[1].res), 32'h00CC);
      chk("mix_res2", 32'(rsp_q[2].res), 32'h000A);
      chk("mix_op1", 32'(rsp_q[1].op), 32'd3);
    end
    if (rise_cyc.size() == 3) begin
      chk("mix_mul_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'd6);
      chk("mix_xor_period", 32'(rise_cyc[2] - rise_cyc[1]), 32'd4);
    end

    // FIFO full with the response port stalled.
    rsp_q.delete();
    r0 = rise_cnt;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sums[i] = 16'(9'(8'hF0 + i) + 9'(8'h20 + i));
      push(8'(8'hF0 + i), 8'(8'h20 + i), 3'd1, w);
      chk($sformatf("full_wait%0d", i), 32'(w), 32'd0);
    end
    sums[5] = 16'h0110 + 16'd10;
    repeat (20) @(negedge clk);
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("full_rsp_hold", 32'(bus.rsp_result), 32'(sums[0]));
    chk("full_issued", 32'(rise_cnt - r0), 32'd1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    push(8'hF5, 8'h25, 3'd1, w);
    chk("full_6th_held", 32'(w > 0), 32'd1);
    wait_idle();
    chk("full_nrsp", 32'(rsp_q.size()), 32'd6);
    if (rsp_q.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("full_res%0d", i), 32'(rsp_q[i].res), 32'(sums[i]));
        chk($sformatf("full_err%0d", i), 32'(rsp_q[i].err), 32'd0);
      end

    // Watchdog: no done at all, then done exactly on the timeout edge, then one edge late.
    rsp_q.delete();
    hang = 1'b1;
    push(8'h05, 8'h06, 3'd1, w);
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.alu_start) hi++;
      else if (hi > 0) break;
    end
    chk("tmo_start_cycles", 32'(hi), 32'd15);
    wait_idle();
    hang = 1'b0;
    chk("tmo_nrsp", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() == 1) begin
      chk("tmo_err", 32'(rsp_q[0].err), 32'd1);
      chk("tmo_res", 32'(rsp_q[0].res), 32'd0);
      chk("tmo_op", 32'(rsp_q[0].op), 32'd1);
    end
    rsp_q.delete();
    lat_ovr = 14;
    push(8'h21, 8'h43, 3'd1, w);
    wait_idle();
    lat_ovr = 15;
    push(8'h21, 8'h43, 3'd1, w);
    wait_idle();
    lat_ovr = 0;
    push(8'h07, 8'h08, 3'd1, w);
    wait_idle();
    chk("tie_nrsp", 32'(rsp_q.size()), 32'd3);
    if (rsp_q.size() == 3) begin
      chk("tie_done_wins_err", 32'(rsp_q[0].err), 32'd0);
      chk("tie_done_wins_res", 32'(rsp_q[0].res), 32'h0064);
      chk("late_done_err", 32'(rsp_q[1].err), 32'd1);
      chk("late_done_res", 32'(rsp_q[1].res), 32'd0);
      chk("post_tmo_res", 32'(rsp_q[2].res), 32'h000F);
      chk("post_tmo_err", 32'(rsp_q[2].err), 32'd0);
    end

    // Reset in the middle of a mul with two more queued.
    rsp_q.delete();
    r0 = rise_cnt;
    push(8'h03, 8'h04, 3'd4, w);
    push(8'h05, 8'h06, 3'd4, w);
    push(8'h07, 8'h08, 3'd4, w);
    @(negedge clk);
    chk("rstmid_start_before", 32'(bus.alu_start), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_start", 32'(bus.alu_start), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rstmid_nrsp", 32'(rsp_q.size()), 32'd0);
    chk("rstmid_no_restart", 32'(rise_cnt - r0), 32'd1);
    chk("rstmid_busy_after", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
